apb_cfg_master: RTL and testbench
=================================

// Module: apb_cfg_master
// PURPOSE
//  APB initiator that drives the accelerator's write-only config register slave
//  from a queue of commands. Sits between the host-side control logic (or a
//  microsequencer) and the config slave. Buffers commands in a small FIFO and
//  issues one APB transfer per command (SETUP then ACCESS). Reports one response
//  per completed transfer, including slave errors.
// PARAMETERS
//  FIFO_DEPTH      4    command FIFO entries; power of 2, >=2
//  ADDR_W          32   APB address width
//  DATA_W          32   APB data width
//  TIMEOUT_CYCLES  16   ACCESS cycles before abort (only with APB_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock
//  resetn         in   1       synchronous active-low reset
//  cmd_valid      in   1       command offered
//  cmd_ready      out  1       command accepted when valid&ready
//  cmd_addr       in   ADDR_W  target register offset (0x0..0x1c)
//  cmd_wdata      in   DATA_W  write data
//  cmd_write      in   1       1=write, 0=read
//  rsp_valid      out  1       one-cycle pulse per completed transfer
//  rsp_rdata      out  DATA_W  PRDATA captured at completion
//  rsp_err        out  1       PSLVERR (or timeout) for that transfer
//  busy           out  1       FIFO non-empty or transfer in flight
//  m_apb_paddr    out  ADDR_W  APB PADDR
//  m_apb_psel     out  1       APB PSEL
//  m_apb_penable  out  1       APB PENABLE
//  m_apb_pwrite   out  1       APB PWRITE
//  m_apb_pwdata   out  DATA_W  APB PWDATA
//  m_apb_pready   in   1       APB PREADY
//  m_apb_prdata   in   DATA_W  APB PRDATA
//  m_apb_pslverr  in   1       APB PSLVERR
// BEHAVIOUR
//  - Reset (resetn=0 at clk edge): FSM->IDLE, FIFO emptied, psel/penable/pwrite=0,
//    paddr/pwdata=0, rsp_valid/rsp_err=0, rsp_rdata=0, busy=0. Reset mid-transfer
//    drops psel/penable at that edge; the in-flight command is lost, and no rsp.
//  - cmd_ready = !full (registered count); a push while full is impossible.
//    Push and pop in the same cycle are both allowed; the count is unchanged.
//  - FSM IDLE: if FIFO non-empty, pop the head and load paddr/pwrite/pwdata;
//    next state is SETUP (psel=1, penable=0).
//  - SETUP: always goes to ACCESS next cycle (psel=1, penable=1). Addr, data and
//    write are held stable through SETUP and ACCESS.
//  - ACCESS: wait while pready=0. On pready=1, capture prdata and pslverr into
//    rsp_*; rsp_valid=1 on the following cycle.
//    - If the FIFO is non-empty, pop and go directly to SETUP (back-to-back,
//      penable=0 for one cycle, psel stays 1).
//    - Else go to IDLE (psel=0, penable=0).
//  - Minimum latency: cmd accepted cycle N -> psel high N+2 -> penable N+3 ->
//    rsp_valid N+4 when pready=1 in ACCESS. Sustained rate is 1 transfer per 2 clk.
//  - rsp has no backpressure; the consumer must take each pulse.
//  - busy = (count!=0) | (state!=IDLE).
//  - The config slave flags reads with PSLVERR=1; that is reported as rsp_err=1
//    with rsp_rdata=0, and is not treated as fatal.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//    - A counter runs in ACCESS. If pready stays 0 for TIMEOUT_CYCLES cycles,
//      the transfer is abandoned with rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    - The FSM then continues as if pready had arrived.
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for pready.
// STRUCTURE
//  - Package bnn_apb_pkg holds:
//    - register offsets REG_WEIGHT_XFER=0x0, REG_LAST_ROW=0x4, REG_LAST_COL=0x8,
//      REG_SYS_START=0xc, REG_ACT_ADDR=0x10, REG_BATCH=0x14, REG_PSUM_ADDR=0x18,
//      REG_ACCUM=0x1c;
//    - the FSM state enum apb_state_t {IDLE,SETUP,ACCESS};
//    - the command struct {addr,wdata,write}.
//  - One sub-module, apb_cmd_fifo: synchronous FIFO with DEPTH and WIDTH
//    parameters, registered count, and full/empty flags. Head data is
//    combinational (first-word fall-through).
// TESTING
//  1. Write 0x4 data 0x1f with pready=1: psel rises 2 cycles after accept,
//     penable 1 later; slave last_row=31; rsp_valid with rsp_err=0.
//  2. Four back-to-back writes (0x4=3, 0x8=7, 0x10=0x100, 0xc=1): 8 APB cycles,
//     penable low between transfers, psel continuous, 4 rsp pulses.
//  3. Read of 0x0: rsp_err=1, rsp_rdata=0; the next queued write still completes.
//  4. Fill FIFO with 4 cmds while pready=0: cmd_ready=0 while full; cmd_ready
//     rises the cycle after the first pop.
//  5. Assert resetn=0 during ACCESS: psel/penable=0 next edge, busy=0, no rsp.
//  6. (APB_TIMEOUT_EN) Hold pready=0 for 16 ACCESS cycles: rsp_err=1, and the FSM
//     returns to IDLE.

Source files
------------

// File: rtl/bnn_apb_pkg.sv
// Shared definitions for the accelerator config-register APB path:
// register map, initiator FSM states and the queued command layout.
package bnn_apb_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  localparam logic [CMD_ADDR_W-1:0] REG_WEIGHT_XFER = 32'h0000_0000;
  localparam logic [CMD_ADDR_W-1:0] REG_LAST_ROW    = 32'h0000_0004;
  localparam logic [CMD_ADDR_W-1:0] REG_LAST_COL    = 32'h0000_0008;
  localparam logic [CMD_ADDR_W-1:0] REG_SYS_START   = 32'h0000_000c;
  localparam logic [CMD_ADDR_W-1:0] REG_ACT_ADDR    = 32'h0000_0010;
  localparam logic [CMD_ADDR_W-1:0] REG_BATCH       = 32'h0000_0014;
  localparam logic [CMD_ADDR_W-1:0] REG_PSUM_ADDR   = 32'h0000_0018;
  localparam logic [CMD_ADDR_W-1:0] REG_ACCUM       = 32'h0000_001c;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic                  write;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with registered count.
// DEPTH must be a power of two so the pointers wrap naturally.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/apb_cfg_master.sv
// APB initiator feeding the config-register slave from a command FIFO.
// Define APB_TIMEOUT_EN to abort ACCESS phases that never see PREADY.
module apb_cfg_master
  import bnn_apb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_write,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_apb_paddr,
  output logic              m_apb_psel,
  output logic              m_apb_penable,
  output logic              m_apb_pwrite,
  output logic [DATA_W-1:0] m_apb_pwdata,
  input  logic              m_apb_pready,
  input  logic [DATA_W-1:0] m_apb_prdata,
  input  logic              m_apb_pslverr
);

  localparam int CMD_W = ADDR_W + DATA_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_cfg_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              fifo_full, fifo_empty, push, pop, tmo, done;
  logic [CNT_W-1:0]  fifo_count;
  logic [CMD_W-1:0]  head;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i ({cmd_addr, cmd_wdata, cmd_write}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (!resetn || state_q != ACCESS) tmo_q <= '0;
    else                              tmo_q <= tmo_q + TMO_W'(1);
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle without PREADY.
  assign tmo = (state_q == ACCESS) && !m_apb_pready &&
               (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (m_apb_pready || tmo);

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          paddr_d  = head[CMD_W-1 -: ADDR_W];
          pwdata_d = head[DATA_W:1];
          pwrite_d = head[0];
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = tmo || m_apb_pslverr;
          rsp_rdata_d = tmo ? '0 : m_apb_prdata;
          // Back-to-back: skip IDLE so PSEL stays high into the next SETUP.
          if (!fifo_empty) begin
            pop      = 1'b1;
            paddr_d  = head[CMD_W-1 -: ADDR_W];
            pwdata_d = head[DATA_W:1];
            pwrite_d = head[0];
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign m_apb_psel    = (state_q != IDLE);
  assign m_apb_penable = (state_q == ACCESS);
  assign m_apb_paddr   = paddr_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pwrite  = pwrite_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master with a behavioural config slave and a
// response scoreboard; the timeout step only runs with APB_TIMEOUT_EN.
module tb_apb_cfg_master;
  import bnn_apb_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_exp_t;

  logic        clk, resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic        slave_ready;
  logic [31:0] sregs [8];

  rsp_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int base;
  apb_cmd_t c;

  apb_cfg_master #(
    .FIFO_DEPTH(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .m_apb_paddr(paddr), .m_apb_psel(psel), .m_apb_penable(penable),
    .m_apb_pwrite(pwrite), .m_apb_pwdata(pwdata), .m_apb_pready(pready),
    .m_apb_prdata(prdata), .m_apb_pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-only slave: reads get PSLVERR with zero data; writes echo a tag.
  assign pready  = slave_ready;
  assign pslverr = psel && penable && !pwrite;
  assign prdata  = (psel && penable && pwrite) ? {16'hA5A5, pwdata[15:0]} : 32'h0;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) sregs[i] <= 32'h0;
    end else if (psel && penable && pready && pwrite) begin
      sregs[paddr[4:2]] <= pwdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input apb_cmd_t cmd, input bit abort);
    rsp_exp_t e;
    cmd_valid = 1'b1;
    cmd_addr  = cmd.addr;
    cmd_wdata = cmd.wdata;
    cmd_write = cmd.write;
    e.err   = abort || !cmd.write;
    e.rdata = (abort || !cmd.write) ? 32'h0 : {16'hA5A5, cmd.wdata[15:0]};
    exp_q.push_back(e);
    $display("cmd  addr=0x%0h wdata=0x%0h write=%0b", cmd.addr, cmd.wdata, cmd.write);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  always @(negedge clk) begin
    rsp_exp_t e;
    if (rsp_valid) begin
      rsp_cnt++;
      $display("rsp  err=%0b rdata=0x%0h", rsp_err, rsp_rdata);
      check("rsp_expected", (exp_q.size() != 0) ? 32'h1 : 32'h0, 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_write = 1'b0;
    slave_ready = 1'b1;
    repeat (3) step();
    check("rst_psel", {31'h0, psel}, 32'h0);
    check("rst_penable", {31'h0, penable}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    resetn = 1'b1;
    step();

    // Single write: PSEL two cycles after accept, PENABLE one later.
    for (int j = 0; j < 6; j++) begin
      step();
      case (j)
        0: begin
          c.addr = REG_LAST_ROW; c.wdata = 32'h1f; c.write = 1'b1;
          drive_cmd(c, 1'b0);
        end
        1: begin
          cmd_valid = 1'b0;
          check("t1_psel_n1", {31'h0, psel}, 32'h0);
          check("t1_busy_n1", {31'h0, busy}, 32'h1);
        end
        2: begin
          check("t1_psel_n2", {31'h0, psel}, 32'h1);
          check("t1_penable_n2", {31'h0, penable}, 32'h0);
        end
        3: begin
          check("t1_penable_n3", {31'h0, penable}, 32'h1);
          check("t1_paddr", paddr, 32'h4);
          check("t1_pwdata", pwdata, 32'h1f);
          check("t1_pwrite", {31'h0, pwrite}, 32'h1);
        end
        4: begin
          check("t1_rsp_valid_n4", {31'h0, rsp_valid}, 32'h1);
          check("t1_psel_n4", {31'h0, psel}, 32'h0);
        end
        default: begin
          check("t1_last_row", sregs[1], 32'd31);
          check("t1_busy_done", {31'h0, busy}, 32'h0);
        end
      endcase
    end

    // Four back-to-back writes: PSEL continuous, PENABLE alternates.
    base = rsp_cnt;
    for (int j = 0; j < 11; j++) begin
      logic exp_psel, exp_pen;
      step();
      exp_psel = (j >= 2) && (j <= 9);
      exp_pen  = exp_psel && (j % 2 == 1);
      check($sformatf("t2_psel_%0d", j), {31'h0, psel}, {31'h0, exp_psel});
      check($sformatf("t2_penable_%0d", j), {31'h0, penable}, {31'h0, exp_pen});
      c.write = 1'b1;
      case (j)
        0: begin c.addr = REG_LAST_ROW;  c.wdata = 32'd3;     drive_cmd(c, 1'b0); end
        1: begin c.addr = REG_LAST_COL;  c.wdata = 32'd7;     drive_cmd(c, 1'b0); end
        2: begin c.addr = REG_ACT_ADDR;  c.wdata = 32'h100;   drive_cmd(c, 1'b0); end
        3: begin c.addr = REG_SYS_START; c.wdata = 32'd1;     drive_cmd(c, 1'b0); end
        default: cmd_valid = 1'b0;
      endcase
    end
    repeat (2) step();
    check("t2_rsp_count", rsp_cnt - base, 32'd4);
    check("t2_last_row", sregs[1], 32'd3);
    check("t2_last_col", sregs[2], 32'd7);
    check("t2_act_addr", sregs[4], 32'h100);
    check("t2_sys_start", sregs[3], 32'd1);

    // Read gets PSLVERR; the queued write behind it still lands.
    base = rsp_cnt;
    step();
    c.addr = REG_WEIGHT_XFER; c.wdata = 32'h0; c.write = 1'b0;
    drive_cmd(c, 1'b0);
    step();
    c.addr = REG_BATCH; c.wdata = 32'd5; c.write = 1'b1;
    drive_cmd(c, 1'b0);
    step();
    cmd_valid = 1'b0;
    wait_idle(40);
    repeat (2) step();
    check("t3_rsp_count", rsp_cnt - base, 32'd2);
    check("t3_batch", sregs[5], 32'd5);
    check("t3_weight_untouched", sregs[0], 32'h0);

    // Fill the FIFO behind a stalled transfer; ready returns after first pop.
    base = rsp_cnt;
    slave_ready = 1'b0;
    for (int j = 0; j < 9; j++) begin
      logic exp_ready;
      step();
      exp_ready = (j <= 4) || (j >= 8);
      check($sformatf("t4_cmd_ready_%0d", j), {31'h0, cmd_ready}, {31'h0, exp_ready});
      c.write = 1'b1;
      case (j)
        0: begin c.addr = REG_PSUM_ADDR; c.wdata = 32'h2000; drive_cmd(c, 1'b0); end
        1: begin c.addr = REG_ACCUM;     c.wdata = 32'd1;    drive_cmd(c, 1'b0); end
        2: begin c.addr = REG_LAST_ROW;  c.wdata = 32'd9;    drive_cmd(c, 1'b0); end
        3: begin c.addr = REG_LAST_COL;  c.wdata = 32'd10;   drive_cmd(c, 1'b0); end
        4: begin c.addr = REG_SYS_START; c.wdata = 32'd2;    drive_cmd(c, 1'b0); end
        5: begin cmd_valid = 1'b0; check("t4_busy_full", {31'h0, busy}, 32'h1); end
        7: slave_ready = 1'b1;
        default: ;
      endcase
    end
    wait_idle(40);
    repeat (2) step();
    check("t4_rsp_count", rsp_cnt - base, 32'd5);
    check("t4_psum_addr", sregs[6], 32'h2000);
    check("t4_accum", sregs[7], 32'd1);
    check("t4_last_row", sregs[1], 32'd9);
    check("t4_sys_start", sregs[3], 32'd2);

    // Reset during ACCESS drops the transfer without a response.
    base = rsp_cnt;
    slave_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      case (j)
        0: begin c.addr = REG_ACT_ADDR; c.wdata = 32'hdead; c.write = 1'b1; drive_cmd(c, 1'b0); end
        1: cmd_valid = 1'b0;
        3: begin
          check("t5_penable_pre", {31'h0, penable}, 32'h1);
          resetn = 1'b0;
        end
        4: begin
          check("t5_psel", {31'h0, psel}, 32'h0);
          check("t5_penable", {31'h0, penable}, 32'h0);
          check("t5_busy", {31'h0, busy}, 32'h0);
          check("t5_rsp_valid", {31'h0, rsp_valid}, 32'h0);
          check("t5_paddr", paddr, 32'h0);
          exp_q.delete();
          resetn = 1'b1;
          slave_ready = 1'b1;
        end
        default: ;
      endcase
    end
    repeat (6) step();
    check("t5_no_rsp", rsp_cnt - base, 32'd0);
    check("t5_no_write", sregs[4], 32'h0);
    check("t5_idle", {31'h0, busy}, 32'h0);

`ifdef APB_TIMEOUT_EN
    // Slave never answers: abort after 16 ACCESS cycles.
    base = rsp_cnt;
    slave_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step();
      case (j)
        0: begin c.addr = REG_LAST_COL; c.wdata = 32'h55; c.write = 1'b1; drive_cmd(c, 1'b1); end
        1: cmd_valid = 1'b0;
        18: begin
          check("t6_psel_last", {31'h0, psel}, 32'h1);
          check("t6_penable_last", {31'h0, penable}, 32'h1);
          check("t6_rsp_early", {31'h0, rsp_valid}, 32'h0);
        end
        19: begin
          check("t6_rsp_valid", {31'h0, rsp_valid}, 32'h1);
          check("t6_psel_idle", {31'h0, psel}, 32'h0);
          check("t6_busy", {31'h0, busy}, 32'h0);
        end
        default: ;
      endcase
    end
    slave_ready = 1'b1;
    repeat (3) step();
    check("t6_rsp_count", rsp_cnt - base, 32'd1);
    check("t6_no_write", sregs[2], 32'h0);
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
